// File: rtl/uart_mem_pkg.sv
// uart_mem_pkg: shared state encoding and constants for the UART memory command sequencer.
package uart_mem_pkg;
  typedef enum logic [2:0] {IDLE, DRAIN, ACCESS, RD_CAP, TX_SEND, TX_WAIT} state_t;
  localparam logic MEM_IMEM = 1'b0;
  localparam logic MEM_DMEM = 1'b1;
  localparam logic CMD_READ = 1'b0;
  localparam logic CMD_WRITE = 1'b1;
  localparam int TX_TIMEOUT = 16;
endpackage

// File: rtl/uart_mem_ctrl_if.sv
// uart_mem_ctrl_if: host command, CPU port, memory port and UART transmit signals of uart_mem_ctrl.
interface uart_mem_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic cmd_valid, cmd_rw, cmd_mem_type;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic cpu_req, cpu_we, cpu_gnt, cpu_stall;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic mem_req, mem_we, mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic tx_start, tx_busy;
  logic [DATA_W-1:0] tx_data;
  logic busy, overrun;
  modport master (
    input cmd_valid, cmd_rw, cmd_mem_type, cmd_addr, cmd_wdata,
    input cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, tx_busy,
    output cpu_gnt, cpu_rdata, cpu_stall, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
    output tx_start, tx_data, busy, overrun
  );
  modport slave (
    output cmd_valid, cmd_rw, cmd_mem_type, cmd_addr, cmd_wdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, tx_busy,
    input cpu_gnt, cpu_rdata, cpu_stall, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
    input tx_start, tx_data, busy, overrun
  );
endinterface

// File: rtl/uart_mem_mux.sv
// uart_mem_mux: steers either the CPU or the latched host command onto the memory port.
module uart_mem_mux
  import uart_mem_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              sel_cmd,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cmd_rw,
  input  logic              cmd_mem_type,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              cpu_gnt,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata
);
  always_comb begin
    cpu_gnt = cpu_req && !sel_cmd;
    mem_req = sel_cmd || cpu_req;
    mem_we = sel_cmd ? cmd_rw : cpu_we;
    mem_sel = sel_cmd ? cmd_mem_type : MEM_DMEM;
    mem_addr = sel_cmd ? cmd_addr : cpu_addr;
    mem_wdata = sel_cmd ? cmd_wdata : cpu_wdata;
  end
endmodule

// File: rtl/uart_mem_ctrl.sv
// uart_mem_ctrl: sequences UART host memory commands onto the shared memory port, stalling the CPU around each access.
// Define UART_MEM_READBACK_EN to execute read commands and return the word through the UART transmitter.
module uart_mem_ctrl
  import uart_mem_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int STALL_DRAIN = 2
) (
  input logic clk,
  input logic reset_n,
  uart_mem_ctrl_if.master bus
);
  localparam int CW = STALL_DRAIN > 1 ? $clog2(STALL_DRAIN) : 1;
  state_t state, nxt;
  logic cmd_rw, cmd_mem_type, accept, sel_cmd, overrun_q;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [CW-1:0] drain_cnt;
`ifdef UART_MEM_READBACK_EN
  localparam int TW = $clog2(TX_TIMEOUT);
  logic [DATA_W-1:0] tx_data_q;
  logic tx_seen;
  logic [TW-1:0] tx_wait_cnt;
  assign accept = bus.cmd_valid && state == IDLE;
`else
  assign accept = bus.cmd_valid && state == IDLE && bus.cmd_rw == CMD_WRITE;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept ? DRAIN : IDLE;
      DRAIN:   nxt = drain_cnt == '0 ? ACCESS : DRAIN;
`ifdef UART_MEM_READBACK_EN
      ACCESS:  nxt = cmd_rw == CMD_WRITE ? IDLE : RD_CAP;
      RD_CAP:  nxt = TX_SEND;
      TX_SEND: nxt = bus.tx_busy ? TX_SEND : TX_WAIT;
      // Leave once the transmitter has gone busy and idle again, or it never went busy within the timeout.
      TX_WAIT: nxt = !bus.tx_busy && (tx_seen || tx_wait_cnt == TW'(TX_TIMEOUT - 1)) ? IDLE : TX_WAIT;
`else
      ACCESS:  nxt = IDLE;
`endif
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    sel_cmd = state == ACCESS;
    bus.cpu_stall = state == DRAIN || state == ACCESS;
    bus.busy = state != IDLE;
    bus.cpu_rdata = bus.mem_rdata;
    bus.overrun = overrun_q;
`ifdef UART_MEM_READBACK_EN
    bus.tx_start = state == TX_SEND && !bus.tx_busy;
    bus.tx_data = tx_data_q;
`else
    bus.tx_start = 1'b0;
    bus.tx_data = '0;
`endif
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cmd_rw <= 1'b0;
      cmd_mem_type <= 1'b0;
      cmd_addr <= '0;
      cmd_wdata <= '0;
      drain_cnt <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (accept) begin
        cmd_rw <= bus.cmd_rw;
        cmd_mem_type <= bus.cmd_mem_type;
        cmd_addr <= bus.cmd_addr;
        cmd_wdata <= bus.cmd_wdata;
      end
      drain_cnt <= accept ? CW'(STALL_DRAIN - 1) : state == DRAIN && drain_cnt != '0 ? drain_cnt - 1'b1 : drain_cnt;
      if (bus.cmd_valid && state != IDLE) overrun_q <= 1'b1;
    end
`ifdef UART_MEM_READBACK_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      tx_data_q <= '0;
      tx_seen <= 1'b0;
      tx_wait_cnt <= '0;
    end else begin
      if (state == RD_CAP) tx_data_q <= bus.mem_rdata;
      tx_seen <= state == TX_WAIT && (tx_seen || bus.tx_busy);
      tx_wait_cnt <= state == TX_WAIT && !tx_seen && !bus.tx_busy ? tx_wait_cnt + 1'b1 : state == TX_WAIT ? tx_wait_cnt : '0;
    end
`endif
  uart_mem_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
    .sel_cmd(sel_cmd),
    .cpu_req(bus.cpu_req),
    .cpu_we(bus.cpu_we),
    .cpu_addr(bus.cpu_addr),
    .cpu_wdata(bus.cpu_wdata),
    .cmd_rw(cmd_rw),
    .cmd_mem_type(cmd_mem_type),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cpu_gnt(bus.cpu_gnt),
    .mem_req(bus.mem_req),
    .mem_we(bus.mem_we),
    .mem_sel(bus.mem_sel),
    .mem_addr(bus.mem_addr),
    .mem_wdata(bus.mem_wdata)
  );
endmodule

// File: tb/tb_uart_mem_ctrl.sv
// tb_uart_mem_ctrl: randomized self-checking bench for uart_mem_ctrl with a memory and UART transmitter model.
module tb_uart_mem_ctrl;
  localparam int SD = 2;
  logic clk = 1'b0, reset_n = 1'b0, force_busy = 1'b0;
  int busy_cnt = 0, tx_count = 0, wr_count = 0;
  int total = 0, bad = 0;
  logic [31:0] imem [512];
  logic [31:0] dmem [512];
  uart_mem_ctrl_if bus ();
  uart_mem_ctrl #(.STALL_DRAIN(SD)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.tx_busy = force_busy || busy_cnt > 0;
  always @(posedge clk) begin
    if (bus.mem_req) begin
      if (bus.mem_we) begin
        if (bus.mem_sel) dmem[bus.mem_addr] <= bus.mem_wdata;
        else imem[bus.mem_addr] <= bus.mem_wdata;
        wr_count <= wr_count + 1;
      end
      bus.mem_rdata <= bus.mem_sel ? dmem[bus.mem_addr] : imem[bus.mem_addr];
    end
    if (bus.tx_start) begin
      busy_cnt <= 4;
      tx_count <= tx_count + 1;
    end else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rw, input logic typ, input logic [8:0] a, input logic [31:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_rw = rw;
    bus.cmd_mem_type = typ;
    bus.cmd_addr = a;
    bus.cmd_wdata = d;
  endtask

  task automatic host_write(input logic typ, input logic [8:0] a, input logic [31:0] d);
    tick();
    issue(1'b1, typ, a, d);
    tick();
    bus.cmd_valid = 1'b0;
    repeat (SD + 2) tick();
  endtask

  task automatic test_reset();
    #2;
    total++; if (bus.cpu_stall !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL reset_stall_busy got=%b%b exp=00", bus.cpu_stall, bus.busy); end
    total++; if (bus.overrun !== 1'b0 || bus.tx_start !== 1'b0) begin bad++; $display("FAIL reset_ovr_txs got=%b%b exp=00", bus.overrun, bus.tx_start); end
    total++; if (bus.tx_data !== 32'h0) begin bad++; $display("FAIL reset_tx_data got=%h exp=0", bus.tx_data); end
    total++; if (bus.mem_req !== 1'b0 || bus.cpu_gnt !== 1'b0) begin bad++; $display("FAIL reset_idle_port got=%b%b exp=00", bus.mem_req, bus.cpu_gnt); end
    bus.cpu_req = 1'b1;
    bus.cpu_addr = 9'h1AB;
    #1;
    total++; if ({bus.cpu_gnt, bus.mem_req, bus.mem_sel, bus.mem_addr} !== {3'b111, 9'h1AB}) begin bad++; $display("FAIL reset_cpu_pass got=%b%b%b %h exp=111 1ab", bus.cpu_gnt, bus.mem_req, bus.mem_sel, bus.mem_addr); end
    bus.cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_write();
    logic typ;
    logic [8:0] a;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      typ = i == 0 ? 1'b1 : 1'($urandom_range(0, 1));
      a = i == 0 ? 9'h010 : 9'($urandom);
      d = i == 0 ? 32'hDEADBEEF : $urandom;
      tick();
      issue(1'b1, typ, a, d);
      for (int c = 0; c <= SD + 3; c++) begin
        if (c > 0) begin tick(); bus.cmd_valid = 1'b0; end
        @(negedge clk);
        total++; if (bus.cpu_stall !== (c >= 1 && c <= SD + 1)) begin bad++; $display("FAIL write_stall c=%0d got=%b", c, bus.cpu_stall); end
        total++; if (bus.mem_req !== (c == SD + 1)) begin bad++; $display("FAIL write_mem_req c=%0d got=%b", c, bus.mem_req); end
        total++; if (bus.busy !== (c >= 1 && c <= SD + 1)) begin bad++; $display("FAIL write_busy c=%0d got=%b", c, bus.busy); end
        if (c == SD + 1) begin
          total++; if ({bus.mem_we, bus.mem_sel, bus.mem_addr, bus.mem_wdata} !== {1'b1, typ, a, d}) begin bad++; $display("FAIL write_access got=%b%b %h %h exp=1%b %h %h", bus.mem_we, bus.mem_sel, bus.mem_addr, bus.mem_wdata, typ, a, d); end
        end
      end
      total++; if ((typ ? dmem[a] : imem[a]) !== d) begin bad++; $display("FAIL write_stored got=%h exp=%h", typ ? dmem[a] : imem[a], d); end
    end
  endtask

`ifdef UART_MEM_READBACK_EN
  task automatic test_read();
    logic typ;
    logic [8:0] a;
    logic [31:0] d;
    int tx0;
    bit done;
    for (int i = 0; i < 4; i++) begin
      typ = i == 0 ? 1'b0 : 1'($urandom_range(0, 1));
      a = i == 0 ? 9'h005 : 9'($urandom);
      d = i == 0 ? 32'h00A00093 : $urandom;
      host_write(typ, a, d);
      tick();
      issue(1'b0, typ, a, 32'h0);
      tx0 = tx_count;
      for (int c = 0; c <= SD + 4; c++) begin
        if (c > 0) begin tick(); bus.cmd_valid = 1'b0; end
        @(negedge clk);
        total++; if (bus.cpu_stall !== (c >= 1 && c <= SD + 1)) begin bad++; $display("FAIL read_stall c=%0d got=%b", c, bus.cpu_stall); end
        total++; if (bus.mem_req !== (c == SD + 1)) begin bad++; $display("FAIL read_mem_req c=%0d got=%b", c, bus.mem_req); end
        total++; if (bus.tx_start !== (c == SD + 3)) begin bad++; $display("FAIL read_tx_start c=%0d got=%b", c, bus.tx_start); end
        if (c == SD + 1) begin
          total++; if ({bus.mem_we, bus.mem_sel, bus.mem_addr} !== {1'b0, typ, a}) begin bad++; $display("FAIL read_access got=%b%b %h exp=0%b %h", bus.mem_we, bus.mem_sel, bus.mem_addr, typ, a); end
        end
        if (c >= SD + 3) begin
          total++; if (bus.tx_data !== d) begin bad++; $display("FAIL read_tx_data c=%0d got=%h exp=%h", c, bus.tx_data, d); end
        end
      end
      done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
        tick();
        @(negedge clk);
        done = !bus.busy;
      end
      total++; if (!done) begin bad++; $display("FAIL read_idle_timeout got=busy exp=idle"); end
      total++; if (tx_count - tx0 != 1) begin bad++; $display("FAIL read_tx_pulses got=%0d exp=1", tx_count - tx0); end
    end
  endtask

  task automatic test_tx_busy();
    logic typ;
    logic [8:0] a;
    logic [31:0] d;
    bit done;
    typ = 1'($urandom_range(0, 1));
    a = 9'($urandom);
    d = $urandom;
    host_write(typ, a, d);
    tick();
    force_busy = 1'b1;
    issue(1'b0, typ, a, 32'h0);
    for (int c = 0; c <= SD + 14; c++) begin
      if (c > 0) begin tick(); bus.cmd_valid = 1'b0; end
      if (c == SD + 13) force_busy = 1'b0;
      @(negedge clk);
      total++; if (bus.tx_start !== (c == SD + 13)) begin bad++; $display("FAIL txbusy_start c=%0d got=%b", c, bus.tx_start); end
      if (c >= SD + 3) begin
        total++; if (bus.tx_data !== d || bus.busy !== 1'b1) begin bad++; $display("FAIL txbusy_hold c=%0d got=%h %b exp=%h 1", c, bus.tx_data, bus.busy, d); end
      end
    end
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      tick();
      @(negedge clk);
      done = !bus.busy;
    end
    total++; if (!done) begin bad++; $display("FAIL txbusy_idle_timeout got=busy exp=idle"); end
  endtask
`else
  task automatic test_read_disabled();
    tick();
    issue(1'b0, 1'($urandom_range(0, 1)), 9'($urandom), 32'h0);
    for (int c = 0; c <= SD + 3; c++) begin
      if (c > 0) begin tick(); bus.cmd_valid = 1'b0; end
      @(negedge clk);
      total++; if ({bus.cpu_stall, bus.mem_req, bus.busy, bus.tx_start, bus.overrun} !== 5'b0) begin bad++; $display("FAIL rd_disabled c=%0d got=%b exp=00000", c, {bus.cpu_stall, bus.mem_req, bus.busy, bus.tx_start, bus.overrun}); end
      total++; if (bus.tx_data !== 32'h0) begin bad++; $display("FAIL rd_disabled_txd got=%h exp=0", bus.tx_data); end
    end
  endtask
`endif

  task automatic test_contention();
    logic typ;
    logic [8:0] a;
    logic [31:0] d;
    typ = 1'($urandom_range(0, 1));
    a = 9'($urandom);
    d = $urandom;
    tick();
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 9'($urandom);
    issue(1'b1, typ, a, d);
    for (int c = 0; c <= SD + 4; c++) begin
      if (c > 0) begin tick(); bus.cmd_valid = 1'b0; bus.cpu_addr = 9'($urandom); end
      @(negedge clk);
      total++; if (bus.cpu_gnt !== (c != SD + 1)) begin bad++; $display("FAIL cont_gnt c=%0d got=%b", c, bus.cpu_gnt); end
      total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL cont_mem_req c=%0d got=%b exp=1", c, bus.mem_req); end
      total++; if (bus.mem_addr !== (c == SD + 1 ? a : bus.cpu_addr) || bus.mem_sel !== (c == SD + 1 ? typ : 1'b1)) begin bad++; $display("FAIL cont_route c=%0d got=%h %b", c, bus.mem_addr, bus.mem_sel); end
      total++; if (bus.cpu_rdata !== bus.mem_rdata) begin bad++; $display("FAIL cont_rdata got=%h exp=%h", bus.cpu_rdata, bus.mem_rdata); end
    end
    bus.cpu_req = 1'b0;
    total++; if ((typ ? dmem[a] : imem[a]) !== d) begin bad++; $display("FAIL cont_stored got=%h exp=%h", typ ? dmem[a] : imem[a], d); end
  endtask

  task automatic test_overrun();
    logic [8:0] a1, a2, seen_addr;
    logic [31:0] d1;
    int n, w0;
    a1 = 9'($urandom);
    a2 = a1 ^ 9'h1;
    d1 = $urandom;
    n = 0;
    seen_addr = '0;
    w0 = wr_count;
    tick();
    @(negedge clk);
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL ovr_initial got=%b exp=0", bus.overrun); end
    tick();
    issue(1'b1, 1'b1, a1, d1);
    for (int c = 0; c <= SD + 4; c++) begin
      if (c > 0) begin tick(); bus.cmd_valid = 1'b0; end
      if (c == 1) issue(1'b1, 1'b1, a2, ~d1);
      @(negedge clk);
      if (bus.mem_req) begin n++; seen_addr = bus.mem_addr; end
    end
    total++; if (n != 1 || seen_addr !== a1) begin bad++; $display("FAIL ovr_single_access got=%0d %h exp=1 %h", n, seen_addr, a1); end
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b exp=1", bus.overrun); end
    total++; if (wr_count - w0 != 1 || dmem[a1] !== d1) begin bad++; $display("FAIL ovr_writes got=%0d %h exp=1 %h", wr_count - w0, dmem[a1], d1); end
  endtask

  task automatic test_reset_mid();
    int n, w0;
    tick();
    issue(1'b1, 1'b1, 9'($urandom), $urandom);
    tick();
    bus.cmd_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    total++; if ({bus.cpu_stall, bus.busy, bus.overrun, bus.mem_req, bus.tx_start} !== 5'b0) begin bad++; $display("FAIL rstmid_outputs got=%b exp=00000", {bus.cpu_stall, bus.busy, bus.overrun, bus.mem_req, bus.tx_start}); end
    total++; if (bus.tx_data !== 32'h0) begin bad++; $display("FAIL rstmid_tx_data got=%h exp=0", bus.tx_data); end
    tick();
    reset_n = 1'b1;
    w0 = wr_count;
    n = 0;
    repeat (8) begin
      tick();
      @(negedge clk);
      if (bus.mem_req || bus.busy) n++;
    end
    total++; if (n != 0 || wr_count != w0) begin bad++; $display("FAIL rstmid_no_access got=%0d %0d exp=0 0", n, wr_count - w0); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_rw = 1'b0;
    bus.cmd_mem_type = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_wdata = '0;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    test_reset();
    test_write();
`ifdef UART_MEM_READBACK_EN
    test_read();
    test_tx_busy();
`else
    test_read_disabled();
`endif
    test_contention();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
